// File: rtl/prog_pkg.sv
// prog_pkg: shared types and constants for the crossbar program loader.
// Holds the loader state enum, programming word width and chain lengths.
package prog_pkg;

    localparam int PROG_W = 32;

    localparam int XBAR_LEN   = 75;
    localparam int V_XBAR_LEN = 68;
    localparam int H_XBAR_LEN = 76;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        VERIFY,
        FINISH
    } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: host bitstream word stream with valid/ready handshake.
// master drives word_i/word_valid; slave (the loader) drives word_ready.
interface prog_loader_if #(
    parameter int W = prog_pkg::PROG_W
) ();

    logic [W-1:0] word_i;
    logic         word_valid;
    logic         word_ready;

    modport master (
        output word_i,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_i,
        input  word_valid,
        output word_ready
    );

endinterface

// File: rtl/prog_cksum.sv
// prog_cksum: 32-bit wrap-around accumulator with synchronous clear and add.
// Ports: clk, res (sync, active-high), clr, add, din, sum.
module prog_cksum
    import prog_pkg::*;
(
    input  logic              clk,
    input  logic              res,
    input  logic              clr,
    input  logic              add,
    input  logic [PROG_W-1:0] din,
    output logic [PROG_W-1:0] sum
);

    logic [PROG_W-1:0] sum_q;
    logic [PROG_W-1:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (add) begin
            sum_d = sum_q + din;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams host words into a crossbar programming chain,
// optionally recirculating the chain once to compare checksums.
// Ports: clk, res, start/len_i/verify_en/abort control, host word stream,
// prog_o/prog_shft/chain_i chain side, busy/done/cfg_ok/cfg_err/checksum_o.
module prog_loader #(
    parameter int LEN_W  = 16,
    parameter int PROG_W = 32
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [LEN_W-1:0]  len_i,
    input  logic              verify_en,
    input  logic              abort,
    prog_loader_if.slave      host,
    output logic [PROG_W-1:0] prog_o,
    output logic              prog_shft,
    input  logic [PROG_W-1:0] chain_i,
    output logic              busy,
    output logic              done,
    output logic              cfg_ok,
    output logic              cfg_err,
    output logic [PROG_W-1:0] checksum_o
);

    import prog_pkg::*;

    localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              ver_q, ver_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;

    logic              clr;
    logic              ld_add;
    logic              rb_add;
    logic [PROG_W-1:0] ld_sum;
    logic [PROG_W-1:0] rb_sum;

    prog_cksum u_ld_cksum (
        .clk (clk),
        .res (res),
        .clr (clr),
        .add (ld_add),
        .din (host.word_i),
        .sum (ld_sum)
    );

    prog_cksum u_rb_cksum (
        .clk (clk),
        .res (res),
        .clr (clr),
        .add (rb_add),
        .din (chain_i),
        .sum (rb_sum)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            ver_q   <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ver_q   <= ver_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ver_d   = ver_q;
        ok_d    = ok_q;
        err_d   = err_q;
        if (abort) begin
            state_d = IDLE;
            ok_d    = 1'b0;
            err_d   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        len_d = len_i;
                        cnt_d = len_i;
                        ver_d = verify_en;
                        err_d = 1'b0;
                        if (len_i == '0) begin
                            ok_d    = 1'b1;
                            state_d = FINISH;
                        end else begin
                            ok_d    = 1'b0;
                            state_d = LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (ld_add) begin
                        cnt_d = cnt_q - ONE;
                        if (cnt_q == ONE) begin
                            if (ver_q) begin
                                cnt_d   = len_q;
                                state_d = VERIFY;
                            end else begin
                                ok_d    = 1'b1;
                                state_d = FINISH;
                            end
                        end
                    end
                end
                VERIFY: begin
                    cnt_d = cnt_q - ONE;
                    if (cnt_q == ONE) begin
                        state_d = FINISH;
                        // Final word is still on chain_i, not yet in rb_sum.
                        if (rb_sum + chain_i == ld_sum) begin
                            ok_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        host.word_ready = 1'b0;
        prog_o          = '0;
        prog_shft       = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        clr             = 1'b0;
        ld_add          = 1'b0;
        rb_add          = 1'b0;
        unique case (state_q)
            IDLE: begin
                clr = start && !abort;
            end
            LOAD: begin
                busy = 1'b1;
                if (!abort) begin
                    host.word_ready = 1'b1;
                    prog_o          = host.word_i;
                    prog_shft       = host.word_valid;
                    ld_add          = host.word_valid;
                end
            end
            VERIFY: begin
                busy = 1'b1;
                if (!abort) begin
                    prog_o    = chain_i;
                    prog_shft = 1'b1;
                    rb_add    = 1'b1;
                end
            end
            FINISH: begin
                done = !abort;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign cfg_ok     = ok_q;
    assign cfg_err    = err_q;
    assign checksum_o = ld_sum;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter LEN_W, default 16, sets the width of the word-count field and counters.
REQ-002 Parameter PROG_W, default 32, sets the programming word width; only 32 is supported.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 res  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  one-cycle pulse beginning a configuration run; honoured only in IDLE.
REQ-006 len_i  input  LEN_W  total chain length in 32-bit words; sampled with start.
REQ-007 verify_en  input  1  request a readback pass after load; sampled with start.
REQ-008 abort  input  1  return to IDLE immediately.
REQ-009 word_i  input  32  host bitstream word.
REQ-010 word_valid  input  1  word_i is valid.
REQ-011 word_ready  output  1  loader accepts word_i this cycle.
REQ-012 prog_o  output  32  drives prog_i of the first crossbar in the chain.
REQ-013 prog_shft  output  1  drives prog_shft of every crossbar in the chain.
REQ-014 chain_i  input  32  prog_o of the last crossbar in the chain.
REQ-015 busy  output  1  high in LOAD and VERIFY.
REQ-016 done  output  1  one-cycle pulse in FINISH.
REQ-017 cfg_ok / cfg_err  output  1 each  run result; held until the next accepted start or reset.
REQ-018 checksum_o  output  32  load checksum of the last run.

Function
REQ-019 The FSM SHALL have exactly four states: IDLE, LOAD, VERIFY and FINISH.
REQ-020 In IDLE, start with len_i!=0 SHALL latch len_i and verify_en, clear both checksums, clear cfg_ok and cfg_err, and enter LOAD on the next cycle.
REQ-021 In IDLE, start with len_i==0 SHALL enter FINISH directly, with cfg_ok=1 and no shift.
REQ-022 word_ready SHALL be 1 only in LOAD.
REQ-023 A word is accepted when word_valid and word_ready are both high.
REQ-024 In LOAD, prog_o SHALL equal word_i and prog_shft SHALL equal word_valid (combinational), so a stalled host produces no shift.
REQ-025 Each accepted word SHALL add word_i to the load checksum (modulo 2^32) and decrement the remaining count.
REQ-026 On acceptance of the len-th word, the FSM SHALL go to VERIFY if verify_en was latched, else to FINISH.
REQ-027 In VERIFY, prog_shft SHALL be 1 every cycle for exactly len cycles.
REQ-028 In VERIFY, prog_o SHALL equal chain_i and chain_i SHALL be added into the readback checksum; the chain therefore recirculates to its loaded contents.
REQ-029 After the len-th VERIFY cycle, the FSM SHALL enter FINISH with cfg_ok=1 if the readback checksum, including the final word, equals the load checksum, else cfg_err=1.
REQ-030 Without verify, FINISH SHALL set cfg_ok=1.
REQ-031 FINISH SHALL last one cycle, assert done, and then return to IDLE.
REQ-032 Outside LOAD and VERIFY, prog_shft=0 and prog_o=0 so that crossbar programming regions stay stable.
REQ-033 abort SHALL have priority over every transition; on abort, next state=IDLE, prog_shft=0 in the abort cycle, cfg_err=1, and no done pulse.
REQ-034 start while busy SHALL be ignored.
REQ-035 Simultaneous start and abort in IDLE: abort wins.
REQ-036 Counters SHALL be LEN_W bits; len=2^LEN_W-1 SHALL complete without wrap.

Reset
REQ-037 res SHALL force IDLE and set word_ready=0, prog_shft=0, prog_o=0, busy=0, done=0, cfg_ok=0, cfg_err=0, checksum_o=0, and both counters to 0.
REQ-038 res mid-LOAD or mid-VERIFY SHALL abandon the run without a done pulse; the chain contents are then undefined and must be reloaded.

Structure
REQ-039 Package prog_pkg SHALL hold the state enum, PROG_W, and the chain-length constants XBAR_LEN=75, V_XBAR_LEN=68 and H_XBAR_LEN=76.
REQ-040 One sub-module, prog_cksum, SHALL implement the 32-bit wrap accumulator with clear/add, instanced twice (load and readback).

Verification
REQ-041 A 3-word chain model with start, len=3, verify_en=0 and words 0x1,0x2,0x3 streamed back-to-back SHALL produce exactly 3 prog_shft cycles, a model holding {3,2,1}, checksum_o=0x6, cfg_ok=1, and done 1 cycle after the last accept.
REQ-042 The same run with word_valid deasserted for 2 cycles between words SHALL produce no prog_shft during the gaps and an identical final contents.
REQ-043 A verify run with len=3 SHALL produce 3 VERIFY shifts, restore the model to {3,2,1}, and set cfg_ok=1; a model bit corrupted before VERIFY SHALL set cfg_err=1.
REQ-044 abort after 1 accepted word SHALL return to IDLE next cycle with cfg_err=1, no done, and prog_shft=0.
REQ-045 start with len=0 SHALL produce done on the following cycle, cfg_ok=1, and no shift; start asserted during LOAD SHALL be ignored.
REQ-046 res asserted mid-VERIFY SHALL give all outputs their reset values on the next cycle.
